uart_stream_tx: RTL
===================

# uart_stream_tx

Transmit end of the UART stream buffer path: drains bytes from the small FIFO's read side and serializes each one as an 8N1 UART frame on the TX pin. It monitors the FIFO free-space count, pops one byte per frame with a single-cycle shift strobe, and sends LSB first at a fixed clocks-per-bit rate. It sits between `Small_FIFO` (`o_Byte` / `o_Free_Space` / `i_Shift_Now`) and the board TX pin.

## Interface
- `CLKS_PER_BIT`, 217: clock cycles per UART bit (25 MHz / 115200). Legal minimum is 2.
- `FIFO_DEPTH`, 4: FIFO capacity. FIFO is empty when `i_Free_Space == FIFO_DEPTH`. Legal range 1..7.
- `i_Clk`  in  1  system clock; all logic on rising edge.
- `i_Rst`  in  1  synchronous, active-high reset.
- `i_Byte`  in  8  FIFO head byte (FIFO `o_Byte`). Valid whenever the FIFO is non-empty.
- `i_Free_Space`  in  3  FIFO free-entry count (FIFO `o_Free_Space`).
- `o_Shift_Now`  out  1  pop strobe to FIFO `i_Shift_Now`. Registered, one cycle per frame.
- `o_Tx_Serial`  out  1  UART line. Registered; idles high.
- `o_Tx_Active`  out  1  high from start bit through stop bit.
- `o_Tx_Done`  out  1  one-cycle pulse after the stop bit completes.

## Operation
- States: `IDLE`, `START`, `DATA`, `[PARITY]`, `STOP`, `CLEANUP`.
- **IDLE**
  - `o_Tx_Serial` = 1.
  - When `i_Free_Space < FIFO_DEPTH` at a rising edge: latch `i_Byte` into the shift register, set `o_Shift_Now` = 1, and go to `START`.
  - `i_Free_Space > FIFO_DEPTH` is illegal and treated as empty.
- **START**: `o_Tx_Serial` = 0 for `CLKS_PER_BIT` cycles. `o_Shift_Now` clears after its first cycle.
- **DATA**
  - Bits 0..7, LSB first, each held `CLKS_PER_BIT` cycles.
  - 3-bit bit index; the bit counter wraps 7 → 0 on exit.
- **STOP**: `o_Tx_Serial` = 1 for `CLKS_PER_BIT` cycles, then go to `CLEANUP`.
- **CLEANUP**: one cycle. `o_Tx_Done` = 1, `o_Tx_Active` = 0, then go to `IDLE`.
- Baud counter width is `$clog2(CLKS_PER_BIT)`. It counts 0..`CLKS_PER_BIT`-1 and resets on every state change.
- Exactly one pop per frame. No pop is issued outside `IDLE`, so the FIFO is never underflowed.
- The byte is latched at pop time. Later changes on `i_Byte` do not affect the frame in flight.
- Concurrent FIFO appends are invisible to this block, apart from `i_Free_Space` changing.
- **Reset**
  - Reset values: state `IDLE`, `o_Tx_Serial` = 1, `o_Shift_Now` = 0, `o_Tx_Active` = 0, `o_Tx_Done` = 0, counters 0.
  - Reset mid-frame aborts the frame: the line goes high on the next edge, the popped byte is discarded, and no pop is issued during reset.
  - Reset takes priority over all other conditions.

## Timing
- Data found available at edge k:
  - `o_Shift_Now`, `o_Tx_Active` and `o_Tx_Serial` = 0 take effect after edge k.
  - The FIFO pops at edge k+1.
- Frame length: `10*CLKS_PER_BIT` cycles, or 11× with parity; `o_Tx_Active` high for exactly this span.
- `o_Tx_Done` is high for the single cycle after the stop bit.
- Back-to-back frames: 2-cycle high gap between stop-bit end and the next start bit (`CLEANUP` + `IDLE` decision).
- `IDLE` samples `i_Free_Space` no earlier than 2 cycles after the previous pop, so the FIFO's registered count has already settled.

## Configuration
- `UART_TX_PARITY_EN` defined:
  - Adds the `PARITY` state between `DATA` and `STOP`.
  - Sends even parity (XOR of the 8 data bits) for `CLKS_PER_BIT` cycles.
  - Frame becomes 11 bit times.
- `UART_TX_PARITY_EN` undefined: plain 8N1, and the `PARITY` state and its XOR logic are absent.

## Test plan
- **Reset idle**: hold `i_Rst` for 2 cycles, `i_Free_Space` = 4 (empty) → `o_Tx_Serial` = 1, `o_Shift_Now` = 0, `o_Tx_Active` = 0, with no activity for 100 cycles.
- **Single byte**: `CLKS_PER_BIT` = 4, `i_Byte` = 8'h2A, `i_Free_Space` = 3 for one pop → one `o_Shift_Now` pulse; line carries 0,0,1,0,1,0,1,0,0,1 at 4 cycles each; `o_Tx_Done` pulses once after 40 cycles.
- **Back-to-back**: FIFO model holding 8'h2A then 8'hD5 → exactly two pops; second start bit begins 2 cycles after the first stop bit ends; decoded bytes 2A, D5; FIFO returns to empty.
- **Latch check**: after the pop, change `i_Byte` to 8'hFF mid-frame → transmitted byte is still 8'h2A.
- **Reset mid-frame**: assert `i_Rst` during data bit 3 → line high on the next edge and `o_Tx_Active` = 0; after release with the FIFO empty, no further frame is sent.
- **Parity (`UART_TX_PARITY_EN`)**: send 8'h07 → parity bit 1 and frame length 44 cycles; send 8'h03 → parity bit 0.

Source files
------------

// File: rtl/uart_stream_tx.sv
// rtl/uart_stream_tx.sv - FIFO-draining 8N1 UART transmitter (even parity bit when UART_TX_PARITY_EN is defined)
module uart_stream_tx #(
    parameter int CLKS_PER_BIT = 217,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic       i_Clk,
    input  logic       i_Rst,
    input  logic [7:0] i_Byte,
    input  logic [2:0] i_Free_Space,
    output logic       o_Shift_Now,
    output logic       o_Tx_Serial,
    output logic       o_Tx_Active,
    output logic       o_Tx_Done
);

    localparam int              CW       = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0]   CNT_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [2:0]      DEPTH    = 3'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_TX_PARITY_EN
        PARITY,
`endif
        STOP,
        CLEANUP
    } state_t;

    state_t          state;
    logic [CW-1:0]   baud_cnt;
    logic [2:0]      bit_idx;
    logic [7:0]      shreg;

    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            state       <= IDLE;
            baud_cnt    <= '0;
            bit_idx     <= '0;
            shreg       <= '0;
            o_Shift_Now <= 1'b0;
            o_Tx_Serial <= 1'b1;
            o_Tx_Active <= 1'b0;
            o_Tx_Done   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    o_Tx_Serial <= 1'b1;
                    o_Tx_Done   <= 1'b0;
                    o_Shift_Now <= 1'b0;
                    baud_cnt    <= '0;
                    bit_idx     <= '0;
                    // Free counts above the depth are nonsense and read as empty.
                    if (i_Free_Space < DEPTH) begin
                        shreg       <= i_Byte;
                        o_Shift_Now <= 1'b1;
                        o_Tx_Active <= 1'b1;
                        o_Tx_Serial <= 1'b0;
                        state       <= START;
                    end
                end
                START: begin
                    o_Shift_Now <= 1'b0;
                    if (baud_cnt == CNT_LAST) begin
                        baud_cnt    <= '0;
                        o_Tx_Serial <= shreg[0];
                        state       <= DATA;
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (baud_cnt == CNT_LAST) begin
                        baud_cnt <= '0;
                        bit_idx  <= bit_idx + 3'd1;
                        if (bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                            o_Tx_Serial <= ^shreg;
                            state       <= PARITY;
`else
                            o_Tx_Serial <= 1'b1;
                            state       <= STOP;
`endif
                        end else begin
                            o_Tx_Serial <= shreg[bit_idx + 3'd1];
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
`ifdef UART_TX_PARITY_EN
                PARITY: begin
                    if (baud_cnt == CNT_LAST) begin
                        baud_cnt    <= '0;
                        o_Tx_Serial <= 1'b1;
                        state       <= STOP;
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
`endif
                STOP: begin
                    if (baud_cnt == CNT_LAST) begin
                        baud_cnt    <= '0;
                        o_Tx_Active <= 1'b0;
                        o_Tx_Done   <= 1'b1;
                        state       <= CLEANUP;
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                CLEANUP: begin
                    o_Tx_Done <= 1'b0;
                    state     <= IDLE;
                end
                default: begin
                    o_Tx_Serial <= 1'b1;
                    o_Tx_Active <= 1'b0;
                    o_Tx_Done   <= 1'b0;
                    o_Shift_Now <= 1'b0;
                    baud_cnt    <= '0;
                    state       <= IDLE;
                end
            endcase
        end
    end

endmodule
